// File: rtl/inv_mix_columns_seq.sv
// AES InvMixColumns engine: accepts a 128-bit state, transforms it one column per clock, returns it over valid/ready.
// Define INV_MIX_COLUMNS_PARALLEL_EN to transform all four columns in a single BUSY cycle.
module inv_mix_columns_seq #(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    // state  | meaning
    // IDLE   | waiting for a state on the input handshake
    // BUSY   | transforming columns of the working register
    // DONE   | result presented, waiting for out_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    logic [1:0]    state;
    logic [CW-1:0] col_cnt;
    logic [127:0]  work;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // One column through the inverse mix matrix; 9/b/d/e built from x2, x4, x8.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign in_ready = (state == S_IDLE);

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    logic [127:0] mixed;

    assign col_cnt = '0;
    assign mixed   = {inv_col(work[127:96]), inv_col(work[95:64]),
                      inv_col(work[63:32]),  inv_col(work[31:0])};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            work      <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work  <= state_in;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work      <= mixed;
                    state_out <= mixed;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    logic [31:0]  col_in;
    logic [31:0]  col_out;
    logic [127:0] work_next;

    always_comb begin
        col_in    = '0;
        work_next = work;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_cnt == CW'(i)) begin
                col_in = work[127-32*i -: 32];
            end
        end
        col_out = inv_col(col_in);
        for (int i = 0; i < NUM_COLS; i++) begin
            if (col_cnt == CW'(i)) begin
                work_next[127-32*i -: 32] = col_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            col_cnt   <= '0;
            work      <= '0;
            state_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        work    <= state_in;
                        col_cnt <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work <= work_next;
                    if (col_cnt == CW'(NUM_COLS - 1)) begin
                        col_cnt   <= '0;
                        state_out <= work_next;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq: reset, known vectors, latency, backpressure, mid-operation reset.
module tb_inv_mix_columns_seq;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    localparam logic [127:0] FIPS_IN  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] COL_IN   = 128'h8e4da1bc_00000000_00000000_00000000;
    localparam logic [127:0] COL_OUT  = 128'hdb135345_00000000_00000000_00000000;
    localparam logic [127:0] ONES     = {16{8'h01}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inv_mix_columns_seq #(.NUM_COLS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out)
    );

    // Drives one accepted state with out_ready low; returns edges to out_valid (-1 on timeout).
    task automatic run_op(input logic [127:0] s, output int lat, output logic [127:0] res);
        @(negedge clk);
        in_valid  = 1'b1;
        state_in  = s;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        res = state_out;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++;
        if (state_out !== 128'h0) begin n_fail++; $display("FAIL reset_state_out got %h want 0", state_out); end
    endtask

    task automatic test_fips();
        int lat;
        logic [127:0] res;
        run_op(FIPS_IN, lat, res);
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL fips_latency got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (res !== FIPS_OUT) begin n_fail++; $display("FAIL fips_result got %h want %h", res, FIPS_OUT); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fips_done_in_ready got %b want 0", in_ready); end
        release_out();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fips_release_valid got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fips_release_ready got %b want 1", in_ready); end
        n_cmp++;
        if (state_out !== FIPS_OUT) begin n_fail++; $display("FAIL fips_hold got %h want %h", state_out, FIPS_OUT); end
    endtask

    task automatic test_single_col();
        int lat;
        logic [127:0] res;
        run_op(COL_IN, lat, res);
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL col_latency got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (res !== COL_OUT) begin n_fail++; $display("FAIL col_result got %h want %h", res, COL_OUT); end
        release_out();
    endtask

    task automatic test_identity_zero();
        int lat;
        logic [127:0] res;
        run_op(ONES, lat, res);
        n_cmp++;
        if (res !== ONES) begin n_fail++; $display("FAIL ones_result got %h want %h", res, ONES); end
        release_out();
        run_op(128'h0, lat, res);
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (res !== 128'h0) begin n_fail++; $display("FAIL zero_result got %h want 0", res); end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] res;
        run_op(COL_IN, lat, res);
        n_cmp++;
        if (res !== COL_OUT) begin n_fail++; $display("FAIL bp_first got %h want %h", res, COL_OUT); end
        @(negedge clk);
        in_valid = 1'b1;
        state_in = ONES;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++;
            if (state_out !== COL_OUT) begin n_fail++; $display("FAIL bp_hold[%0d] got %h want %h", i, state_out, COL_OUT); end
            n_cmp++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
            n_cmp++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept got %b want 0", in_ready); end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL bp_second_latency got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (state_out !== ONES) begin n_fail++; $display("FAIL bp_second_result got %h want %h", state_out, ONES); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] res;
        @(negedge clk);
        in_valid = 1'b1;
        state_in = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", in_ready); end
        n_cmp++;
        if (state_out !== 128'h0) begin n_fail++; $display("FAIL midrst_state_out got %h want 0", state_out); end
        run_op(COL_IN, lat, res);
        n_cmp++;
        if (lat !== LAT) begin n_fail++; $display("FAIL midrst_after_latency got %0d want %0d", lat, LAT); end
        n_cmp++;
        if (res !== COL_OUT) begin n_fail++; $display("FAIL midrst_after_result got %h want %h", res, COL_OUT); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_single_col();
        test_identity_zero();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
